// File: rtl/float_multiply.sv
// ---------------------------------------------------------------------------
// float_multiply
//    Pipelined IEEE-754 binary32 multiplier, round to nearest / ties to even.
//    Subnormal inputs are treated as signed zero and results too small to be
//    normal are flushed to signed zero. Any NaN input, or zero times infinity,
//    yields the canonical quiet NaN 0x7FC00000. No exception flags are raised.
//
//    Timing: operands sampled at edge N are visible on OUT after edge N+2.
//    A new operand pair is accepted on every edge.
//
// Ports
//    clk   : rising-edge clock for all state
//    reset : synchronous, active-low; clears every pipeline register
//    IN1   : operand A (binary32)
//    IN2   : operand B (binary32)
//    OUT   : registered product A*B (binary32)
// ---------------------------------------------------------------------------
module float_multiply (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IN1,
   input  logic [31:0] IN2,
   output logic [31:0] OUT
);

   // ------------------------------------------------------------------
   // Operand unpacking and classification
   // ------------------------------------------------------------------
   logic [7:0]  exp_a, exp_b;
   logic [22:0] frac_a, frac_b;
   logic        sign_in;
   logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;

   assign exp_a   = IN1[30:23];
   assign exp_b   = IN2[30:23];
   assign frac_a  = IN1[22:0];
   assign frac_b  = IN2[22:0];
   assign sign_in = IN1[31] ^ IN2[31];

   // An exponent of zero covers both true zero and subnormals, which are
   // flushed to zero before they ever reach the multiplier.
   assign zero_a = (exp_a == 8'h00);
   assign zero_b = (exp_b == 8'h00);
   assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
   assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
   assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
   assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);

   // Special-case results are fully decided here and simply carried down
   // the pipeline, bypassing the arithmetic path.
   logic        special_in;
   logic [31:0] special_val_in;

   always_comb begin
      special_in     = 1'b1;
      special_val_in = 32'h0000_0000;
      if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
         special_val_in = 32'h7FC0_0000;
      end else if (inf_a || inf_b) begin
         special_val_in = {sign_in, 8'hFF, 23'd0};
      end else if (zero_a || zero_b) begin
         special_val_in = {sign_in, 31'd0};
      end else begin
         special_in = 1'b0;
      end
   end

   // Full 24x24 significand product and unbiased-then-rebiased exponent sum.
   // Ten signed bits hold every intermediate exponent, including negatives
   // from underflow and the +2 worst case from normalize plus round carry.
   logic [47:0]       prod_in;
   logic signed [9:0] exp_sum_in;

   assign prod_in    = {24'd0, 1'b1, frac_a} * {24'd0, 1'b1, frac_b};
   assign exp_sum_in = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

   // ------------------------------------------------------------------
   // Stage 1 registers: raw product and exponent sum
   // ------------------------------------------------------------------
   logic              s1_sign;
   logic signed [9:0] s1_exp;
   logic [47:0]       s1_prod;
   logic              s1_special;
   logic [31:0]       s1_special_val;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_sign        <= 1'b0;
         s1_exp         <= 10'sd0;
         s1_prod        <= 48'd0;
         s1_special     <= 1'b0;
         s1_special_val <= 32'h0000_0000;
      end else begin
         s1_sign        <= sign_in;
         s1_exp         <= exp_sum_in;
         s1_prod        <= prod_in;
         s1_special     <= special_in;
         s1_special_val <= special_val_in;
      end
   end

   // ------------------------------------------------------------------
   // Normalization and rounding
   // ------------------------------------------------------------------
   // The product of two values in [1,2) lies in [1,4); a set top bit means
   // the value is in [2,4) and the binary point moves one place left.
   logic [23:0]       mant_norm;
   logic              guard, round_bit, sticky;
   logic signed [9:0] exp_norm;

   always_comb begin
      if (s1_prod[47]) begin
         mant_norm = s1_prod[47:24];
         guard     = s1_prod[23];
         round_bit = s1_prod[22];
         sticky    = |s1_prod[21:0];
         exp_norm  = s1_exp + 10'sd1;
      end else begin
         mant_norm = s1_prod[46:23];
         guard     = s1_prod[22];
         round_bit = s1_prod[21];
         sticky    = |s1_prod[20:0];
         exp_norm  = s1_exp;
      end
   end

   // Ties (guard set, nothing below it) round up only when the kept LSB is
   // odd. A carry out of the 24-bit significand leaves the fraction bits all
   // zero, so only the exponent needs bumping on renormalization.
   logic              round_up;
   logic [24:0]       mant_rounded;
   logic signed [9:0] exp_rounded;
   logic [22:0]       frac_rounded;
   logic              unused_hidden;

   assign round_up      = guard & (round_bit | sticky | mant_norm[0]);
   assign mant_rounded  = {1'b0, mant_norm} + {24'd0, round_up};
   assign exp_rounded   = mant_rounded[24] ? (exp_norm + 10'sd1) : exp_norm;
   assign frac_rounded  = mant_rounded[22:0];
   assign unused_hidden = mant_rounded[23];

   // ------------------------------------------------------------------
   // Stage 2 registers: rounded significand and exponent
   // ------------------------------------------------------------------
   logic              s2_sign;
   logic signed [9:0] s2_exp;
   logic [22:0]       s2_frac;
   logic              s2_special;
   logic [31:0]       s2_special_val;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s2_sign        <= 1'b0;
         s2_exp         <= 10'sd0;
         s2_frac        <= 23'd0;
         s2_special     <= 1'b0;
         s2_special_val <= 32'h0000_0000;
      end else begin
         s2_sign        <= s1_sign;
         s2_exp         <= exp_rounded;
         s2_frac        <= frac_rounded;
         s2_special     <= s1_special;
         s2_special_val <= s1_special_val;
      end
   end

   // ------------------------------------------------------------------
   // Output register: range check and packing
   // ------------------------------------------------------------------
   // Exponents at or below zero would need a subnormal encoding, which is
   // not produced; they collapse to signed zero. Anything at 255 or above
   // saturates to signed infinity.
   always_ff @(posedge clk) begin
      if (!reset) begin
         OUT <= 32'h0000_0000;
      end else if (s2_special) begin
         OUT <= s2_special_val;
      end else if (s2_exp <= 10'sd0) begin
         OUT <= {s2_sign, 31'd0};
      end else if (s2_exp >= 10'sd255) begin
         OUT <= {s2_sign, 8'hFF, 23'd0};
      end else begin
         OUT <= {s2_sign, s2_exp[7:0], s2_frac};
      end
   end

endmodule

// File: tb/tb_float_multiply.sv
// ---------------------------------------------------------------------------
// tb_float_multiply
//    Self-checking bench for float_multiply: a table of directed vectors,
//    a mid-pipeline reset sequence, and randomized operands compared against
//    an arithmetic reference model of binary32 multiplication.
// ---------------------------------------------------------------------------
module tb_float_multiply;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in1, in2, out;

   float_multiply dut (
      .clk   (clk),
      .reset (reset),
      .IN1   (in1),
      .IN2   (in2),
      .OUT   (out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expected;
      string       name;
   } vec_t;

   vec_t vecs[$];

   int checks = 0;
   int errors = 0;

   // Expected-value delay line: what the output should show once each
   // sampled operand pair has travelled through the two pipeline stages.
   logic [31:0] cur_exp, exp_s1, exp_s2, exp_out;
   string       cur_name, name_s1, name_s2, name_out;

   // Reference product: exact integer significand product, then round to a
   // 24-bit significand by comparing the discarded remainder to half an ulp.
   function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
      logic            sign;
      int              ea, eb, e, p, sh;
      longint unsigned ma, mb, prod, q, rem, half;
      logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
      sign   = a[31] ^ b[31];
      ea     = int'(a[30:23]);
      eb     = int'(b[30:23]);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      a_inf  = (ea == 255) && (a[22:0] == 23'd0);
      b_inf  = (eb == 255) && (b[22:0] == 23'd0);
      a_nan  = (ea == 255) && (a[22:0] != 23'd0);
      b_nan  = (eb == 255) && (b[22:0] != 23'd0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
      if (a_inf || b_inf) return {sign, 8'hFF, 23'd0};
      if (a_zero || b_zero) return {sign, 31'd0};
      ma   = (64'd1 << 23) | {41'd0, a[22:0]};
      mb   = (64'd1 << 23) | {41'd0, b[22:0]};
      prod = ma * mb;
      p    = (prod >= (64'd1 << 47)) ? 47 : 46;
      sh   = p - 23;
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
         q = q >> 1;
         p = p + 1;
      end
      e = ea + eb - 127 + (p - 46);
      if (e <= 0) return {sign, 31'd0};
      if (e >= 255) return {sign, 8'hFF, 23'd0};
      return {sign, 8'(e), q[22:0]};
   endfunction

   // Random operands biased toward the interesting exponent regions.
   function automatic logic [31:0] randOperand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 9))
         0: r[30:23] = 8'h00;
         1: begin
            r[30:23] = 8'hFF;
            if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0;
         end
         2: r[30:23] = 8'($urandom_range(1, 40));
         3: r[30:23] = 8'($urandom_range(215, 254));
         default: r[30:23] = 8'($urandom_range(64, 190));
      endcase
      return r;
   endfunction

   task automatic addVec(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expected, input string name);
      vec_t v;
      v.a        = a;
      v.b        = b;
      v.expected = expected;
      v.name     = name;
      vecs.push_back(v);
   endtask

   task automatic checkOutput();
      checks++;
      if (out !== exp_out) begin
         errors++;
         $display("[TB] FAIL %s: OUT=%08h expected=%08h", name_out, out, exp_out);
      end
   endtask

   // One clock: advance the expected delay line exactly as the sampled
   // reset dictates, then compare the registered output just after the edge.
   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         exp_out  = 32'h0;  name_out = "reset_clear";
         exp_s2   = 32'h0;  name_s2  = "reset_clear";
         exp_s1   = 32'h0;  name_s1  = "reset_clear";
      end else begin
         exp_out  = exp_s2;  name_out = name_s2;
         exp_s2   = exp_s1;  name_s2  = name_s1;
         exp_s1   = cur_exp; name_s1  = cur_name;
      end
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] expected, input string name);
      in1      = a;
      in2      = b;
      cur_exp  = expected;
      cur_name = name;
      tick();
   endtask

   initial begin
      reset    = 1'b0;
      in1      = 32'h0;
      in2      = 32'h0;
      cur_exp  = 32'h0;
      cur_name = "idle";
      exp_s1   = 32'h0;
      exp_s2   = 32'h0;
      exp_out  = 32'h0;
      name_s1  = "idle";
      name_s2  = "idle";
      name_out = "idle";

      // Two reset edges: output must read zero after each.
      tick();
      tick();
      reset = 1'b1;

      addVec(32'h415A0000, 32'hBE200000, 32'hC0084000, "basic_13.625x-0.15625");
      addVec(32'h5D5A07F0, 32'h0E2301C0, 32'h2C0AD48B, "norm_shift_round_down");
      addVec(32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_times_zero");
      addVec(32'h7F000000, 32'h40000000, 32'h7F800000, "overflow_to_inf");
      addVec(32'h00800000, 32'h3F000000, 32'h00000000, "underflow_flush");
      addVec(32'h3F800001, 32'h3F800001, 32'h3F800002, "round_sticky_down");
      addVec(32'h3F800000, 32'h3F800000, 32'h3F800000, "one_times_one");
      addVec(32'h40400000, 32'h40400000, 32'h41100000, "three_squared");
      addVec(32'h3F800800, 32'h3F800800, 32'h3F801000, "tie_to_even_down");
      addVec(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, "round_carry_out");
      addVec(32'h80000001, 32'h3F800000, 32'h80000000, "subnormal_neg_flush");
      addVec(32'h7FC12345, 32'h3F800000, 32'h7FC00000, "nan_input");
      addVec(32'hFF800000, 32'h40000000, 32'hFF800000, "neg_inf_times_two");
      addVec(32'h00800000, 32'h3F800000, 32'h00800000, "min_normal_kept");
      addVec(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, "max_normal_kept");
      addVec(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "max_times_two_inf");
      addVec(32'hC0000000, 32'h00000000, 32'h80000000, "neg_times_zero");

      // Applied back to back, one pair per cycle.
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expected, vecs[i].name);
      end
      applyStimulus(32'h0, 32'h0, 32'h0, "drain");
      applyStimulus(32'h0, 32'h0, 32'h0, "drain");

      // Reset in the middle of traffic: both pairs in flight are discarded
      // and the pair presented during reset never emerges.
      applyStimulus(32'h415A0000, 32'hBE200000, 32'hC0084000, "pre_reset_a");
      applyStimulus(32'h3F800000, 32'h40400000, 32'h40400000, "pre_reset_b");
      reset = 1'b0;
      applyStimulus(32'h40400000, 32'h40400000, 32'h41100000, "during_reset");
      reset = 1'b1;
      applyStimulus(32'h3F800001, 32'h3F800001, 32'h3F800002, "post_reset");
      applyStimulus(32'h40400000, 32'h3F000000, 32'h3FC00000, "post_reset_b");
      applyStimulus(32'h0, 32'h0, 32'h0, "drain");
      applyStimulus(32'h0, 32'h0, 32'h0, "drain");

      // Randomized traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         a = randOperand();
         b = randOperand();
         applyStimulus(a, b, refMul(a, b), "random");
      end
      applyStimulus(32'h0, 32'h0, 32'h0, "drain");
      applyStimulus(32'h0, 32'h0, 32'h0, "drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/float_multiply.md
FLOAT_MULTIPLY -- requirements
Module: float_multiply

Interface
REQ-001 SHALL have exactly one clock domain and no parameters.
REQ-002 SHALL provide `clk` (input, 1 bit): rising-edge clock for all state.
REQ-003 SHALL provide `reset` (input, 1 bit): synchronous, active-low reset, sampled on the `clk` rising edge.
REQ-004 SHALL provide `IN1` (input, 32 bits): IEEE-754 binary32 operand A; bit 31 sign, bits 30:23 exponent, bits 22:0 fraction.
REQ-005 SHALL provide `IN2` (input, 32 bits): IEEE-754 binary32 operand B, same format as `IN1`.
REQ-006 SHALL provide `OUT` (output, 32 bits, registered): binary32 product A*B.

Function
REQ-007 SHALL sample `IN1`/`IN2` on every rising edge; no valid/ready handshake.
REQ-008 SHALL be a 2-stage pipeline: operands sampled at edge N appear on `OUT` after edge N+2.
REQ-009 SHALL accept a new operand pair every cycle (throughput 1).
REQ-010 SHALL compute sign = IN1[31] XOR IN2[31] for all cases, NaN excepted.
REQ-011 SHALL form 24-bit significands with hidden bit 1, multiply them to a 48-bit product, and add exponents minus bias 127 using at least 10-bit signed arithmetic.
REQ-012 SHALL normalize the product: if bit 47 is set, shift right 1 and add 1 to the exponent.
REQ-013 SHALL round to nearest, ties to even, using guard, round and sticky bits.
REQ-014 SHALL, on rounding carry-out of the significand, renormalize and add 1 to the exponent.
REQ-015 SHALL flush subnormal inputs (exponent 0, fraction nonzero) to zero of the same sign.
REQ-016 SHALL flush results with biased exponent <= 0 to signed zero (no subnormal outputs).
REQ-017 SHALL return signed infinity (exp 0xFF, fraction 0) when the biased exponent >= 255 after rounding.
REQ-018 SHALL return canonical NaN 0x7FC00000 if either input is NaN, or for 0 * Inf.
REQ-019 SHALL return signed infinity for Inf * finite-nonzero.
REQ-020 SHALL return signed zero for zero * finite.
REQ-021 SHALL raise no exception flags.

Reset
REQ-022 SHALL, when `reset` = 0 at a rising edge, clear all pipeline registers and drive `OUT` = 0x00000000 from that edge.
REQ-023 SHALL discard in-flight operands on a mid-operation reset; results resume only for operands sampled after `reset` returns to 1.
REQ-024 SHALL produce its first valid result 2 edges after the first edge sampled with `reset` = 1.

Verification
REQ-025 SHALL pass: `reset` = 0 for 2 edges -> `OUT` = 0x00000000.
REQ-026 SHALL pass: `IN1` = 0x415A0000 (13.625), `IN2` = 0xBE200000 (-0.15625) -> `OUT` = 0xC0084000 (-2.12890625) after 2 cycles.
REQ-027 SHALL pass: `IN1` = 0x5D5A07F0, `IN2` = 0x0E2301C0 -> `OUT` = 0x2C0AD48B (normalize shift, round down).
REQ-028 SHALL pass: `IN1` = 0x7F800000, `IN2` = 0x00000000 -> 0x7FC00000; `IN1` = 0x7F000000, `IN2` = 0x40000000 -> 0x7F800000.
REQ-029 SHALL pass: `IN1` = 0x00800000, `IN2` = 0x3F000000 -> 0x00000000 (underflow flush); `IN1` = 0x3F800001, `IN2` = 0x3F800001 -> 0x3F800002.
REQ-030 SHALL pass: back-to-back pairs on consecutive cycles -> results in order, one per cycle, each 2 cycles after its pair.
